// File: rtl/jtdsp16_prog_loader.sv
// Streams a byte-wide program image into the DSP16 program ROM programming port.
// Optional running checksum enabled by defining JTDSP16_LOADER_CHECKSUM_EN.
module jtdsp16_prog_loader #(
  parameter int LEN  = 8192,
  parameter int SWAP = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  dl_data,
  input  logic        dl_valid,
  output logic        dl_ready,
  output logic [12:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic        prog_we,
  output logic        busy,
  output logic        done,
  output logic [15:0] cksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [12:0] LAST     = 13'(LEN - 1);
  localparam logic [12:0] ADDR_XOR = {12'd0, (SWAP != 0)};

  state_t      state;
  logic [12:0] cnt;
  logic        accept;

  // start wins over any byte offered in the same cycle
  assign dl_ready = (state == LOAD) & ~start;
  assign accept   = dl_valid & dl_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      prog_we <= accept;
      if (accept) begin
        prog_addr <= cnt ^ ADDR_XOR;
        prog_data <= dl_data;
      end
      if (start) begin
        state <= LOAD;
        cnt   <= '0;
        busy  <= 1'b1;
        done  <= 1'b0;
      end else if (accept) begin
        if (cnt == LAST) begin
          // counter parks on the last address so a full 8 KiB load never wraps
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          cnt <= cnt + 13'd1;
        end
      end
    end
  end

`ifdef JTDSP16_LOADER_CHECKSUM_EN
  logic [15:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sum <= '0;
    else if (start)
      sum <= '0;
    else if (accept)
      sum <= sum + {8'd0, dl_data};
  end

  assign cksum = sum;
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_jtdsp16_prog_loader.sv
// Directed self-checking bench for jtdsp16_prog_loader: full load, swap, back-pressure,
// abort/restart and reset behaviour across three parameterisations.
module tb_jtdsp16_prog_loader;

`ifdef JTDSP16_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // u0: LEN=8192 SWAP=0, u1: LEN=4 SWAP=1, u2: LEN=4 SWAP=0
  logic        start0, valid0, ready0, we0, busy0, done0;
  logic [7:0]  data0, pdata0;
  logic [12:0] addr0;
  logic [15:0] ck0;
  logic        start1, valid1, ready1, we1, busy1, done1;
  logic [7:0]  data1, pdata1;
  logic [12:0] addr1;
  logic [15:0] ck1;
  logic        start2, valid2, ready2, we2, busy2, done2;
  logic [7:0]  data2, pdata2;
  logic [12:0] addr2;
  logic [15:0] ck2;

  jtdsp16_prog_loader #(.LEN(8192), .SWAP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dl_data(data0), .dl_valid(valid0),
    .dl_ready(ready0), .prog_addr(addr0), .prog_data(pdata0), .prog_we(we0),
    .busy(busy0), .done(done0), .cksum(ck0));

  jtdsp16_prog_loader #(.LEN(4), .SWAP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dl_data(data1), .dl_valid(valid1),
    .dl_ready(ready1), .prog_addr(addr1), .prog_data(pdata1), .prog_we(we1),
    .busy(busy1), .done(done1), .cksum(ck1));

  jtdsp16_prog_loader #(.LEN(4), .SWAP(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dl_data(data2), .dl_valid(valid2),
    .dl_ready(ready2), .prog_addr(addr2), .prog_data(pdata2), .prog_we(we2),
    .busy(busy2), .done(done2), .cksum(ck2));

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned busy_cycles;
  logic [15:0] cs0;
  logic [7:0]  sw_bytes [4];
  logic [12:0] sw_addrs [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds n consecutive bytes into u0 and checks every resulting write cycle
  task automatic load0(input int n, input bit pat, input string tag);
    int errs = 0;
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = pat ? 8'(k * 3 + 1) : 8'(k);
      data0  = b;
      valid0 = 1'b1;
      #1;
      if (ready0 !== 1'b1) errs++;
      tick();
      cs0 = cs0 + {8'd0, b};
      if (we0 !== 1'b1 || addr0 !== 13'(k) || pdata0 !== b) errs++;
      if (ck0 !== (CK_EN ? cs0 : 16'd0)) errs++;
      if (done0 !== (k == 8191)) errs++;
      if (busy0 !== (k != 8191)) errs++;
      if (busy0 === 1'b1) busy_cycles++;
    end
    check({tag, "_errs"}, 64'(errs), 64'd0);
  endtask

  initial begin
    sw_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    sw_addrs = '{13'd1, 13'd0, 13'd3, 13'd2};
    rst_n = 1'b0;
    start0 = 1'b1; valid0 = 1'b1; data0 = 8'hA5;
    start1 = 1'b1; valid1 = 1'b1; data1 = 8'hA5;
    start2 = 1'b1; valid2 = 1'b1; data2 = 8'hA5;
    repeat (3) tick();
    check("rst_u0", {ready0, we0, addr0, pdata0, busy0, done0, ck0}, 64'd0);
    check("rst_u1", {ready1, we1, addr1, pdata1, busy1, done1, ck1}, 64'd0);
    check("rst_u2", {ready2, we2, addr2, pdata2, busy2, done2, ck2}, 64'd0);
    start0 = 1'b0; valid0 = 1'b0;
    start1 = 1'b0; valid1 = 1'b0;
    start2 = 1'b0; valid2 = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_u0", {ready0, we0, addr0, pdata0, busy0, done0, ck0}, 64'd0);

    // Full load with a byte offered in the start cycle
    cs0 = '0;
    start0 = 1'b1; valid0 = 1'b1; data0 = 8'hEE;
    #1;
    check("start_ready", ready0, 1'b0);
    tick();
    start0 = 1'b0;
    check("start_busy", {busy0, done0, we0}, 3'b100);
    busy_cycles = 1;
    load0(8192, 1'b0, "full");
    check("full_busy_cycles", busy_cycles, 8192);
    check("full_cksum", ck0, CK_EN ? 16'hF000 : 16'h0000);
    tick();
    check("post_full", {we0, ready0, done0, busy0, addr0}, {4'b0010, 13'd8191});

    // Restart from DONE, then abort after 100 bytes
    start0 = 1'b1;
    #1;
    check("done_start_ready", ready0, 1'b0);
    tick();
    start0 = 1'b0;
    check("restart_state", {done0, busy0, we0}, 3'b010);
    check("restart_cksum", ck0, 16'd0);
    cs0 = '0;
    load0(100, 1'b1, "pre_abort");
    start0 = 1'b1;
    #1;
    check("abort_ready", ready0, 1'b0);
    tick();
    start0 = 1'b0;
    check("abort_state", {we0, busy0, done0, addr0}, {3'b010, 13'd99});
    check("abort_cksum", ck0, 16'd0);
    cs0 = '0;
    load0(8192, 1'b0, "after_abort");

    // SWAP=1 word byte-order
    start1 = 1'b1; valid1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data1 = sw_bytes[k];
      tick();
      check("swap_we", we1, 1'b1);
      check("swap_addr", addr1, sw_addrs[k]);
      check("swap_data", pdata1, sw_bytes[k]);
    end
    #1;
    check("swap_end", {done1, ready1}, 2'b10);
    check("swap_cksum", ck1, CK_EN ? 16'h00AA : 16'h0000);

    // Alternating dl_valid
    start2 = 1'b1; valid2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      valid2 = (i % 2 == 0);
      data2  = 8'(8'h80 + i);
      tick();
      if (i % 2 == 0) begin
        check("bp_we", we2, 1'b1);
        check("bp_write", {addr2, pdata2}, {13'(i / 2), 8'(8'h80 + i)});
      end else begin
        check("bp_idle_we", we2, 1'b0);
      end
    end
    check("bp_done", {done2, busy2}, 2'b10);

    // Asynchronous reset in the middle of a load
    start2 = 1'b1;
    tick();
    start2 = 1'b0; valid2 = 1'b1; data2 = 8'h3C;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", {ready2, we2, addr2, pdata2, busy2, done2, ck2}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
